bp_cfg_boot_sequencer: RTL and testbench
========================================

Name: bp_cfg_boot_sequencer

Overview:
- Drives the chip configuration bus, whose widths come from the processor config: core select, address and data.
- Out of reset it runs a fixed boot script for every core:
  - freeze the core
  - program its core ID
  - program its CCE mode
  - unfreeze all cores once every core is programmed
- After boot it shares the same bus with a host requester, carrying one outstanding request at a time; a read holds the bus until its response returns.

Parameters:
- num_core_p, 1, number of cores to program (1..2^cfg_core_width_p-1).
- cfg_core_width_p, 8, width of core select.
- cfg_addr_width_p, 16, width of config register address.
- cfg_data_width_p, 64, width of config data.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous assert, active-low.
- cce_mode_i  in  1  CCE mode written during boot (0 = uncached, 1 = normal); sampled when each MODE write is issued.
- cfg_v_o  out  1  config request valid.
- cfg_ready_i  in  1  bus accepts request; a transfer completes when cfg_v_o & cfg_ready_i.
- cfg_w_o  out  1  1 = write, 0 = read.
- cfg_core_o  out  cfg_core_width_p  target core.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data.
- cfg_resp_v_i  in  1  read response valid (single cycle).
- cfg_resp_data_i  in  cfg_data_width_p  read data.
- host_v_i  in  1  host request valid.
- host_ready_o  out  1  host request accepted this cycle.
- host_w_i, host_core_i, host_addr_i, host_data_i  in  1/core/addr/data widths  host request fields.
- host_resp_v_o  out  1  read data to host (single cycle).
- host_resp_data_o  out  cfg_data_width_p  read data to host.
- boot_done_o  out  1  boot script complete; stays high until reset.

Behaviour:
Reset values: all outputs 0 during reset; state = S_FREEZE; core counter = 0.

Register map used by the boot script:
- FREEZE = 16'h0001
- CORE_ID = 16'h0002
- CCE_MODE = 16'h0003

States:
- S_FREEZE: drive a write of 1 to FREEZE for the current core. On handshake go to S_ID.
- S_ID: drive a write of the core counter to CORE_ID (zero-extended). On handshake go to S_MODE.
- S_MODE: drive a write of cce_mode_i to CCE_MODE (zero-extended). On handshake:
  - if counter == num_core_p-1: clear counter, go to S_UNFREEZE
  - else: increment counter, go to S_FREEZE
- S_UNFREEZE: drive a write of 0 to FREEZE for the current core. On handshake:
  - if last core: go to S_IDLE and set boot_done_o the next cycle
  - else: increment counter and stay in S_UNFREEZE
- S_IDLE: host_ready_o = cfg_ready_i (combinational pass-through); cfg_* fields mirror host_* and cfg_v_o = host_v_i.
  - On a host handshake with host_w_i = 0: go to S_RESP.
  - A write stays in S_IDLE.
- S_RESP: cfg_v_o = 0 and host_ready_o = 0. On cfg_resp_v_i:
  - host_resp_v_o = 1 and host_resp_data_o = cfg_resp_data_i in the same cycle (combinational)
  - go to S_IDLE.

Rules:
- In every boot state, host_ready_o = 0 and the host is stalled.
- Once cfg_v_o is asserted, all cfg_* outputs are held stable until the handshake; valid never drops without a handshake.
- cfg_resp_v_i outside S_RESP is ignored; host_resp_v_o stays 0.
- The core counter is $clog2(num_core_p)+1 bits, compared for equality against num_core_p-1. It never wraps past num_core_p-1.
- With num_core_p = 1 the script is exactly four writes.
- Reset asserted mid-script or mid-read aborts immediately. Any in-flight read response is dropped and the script restarts from core 0.
- Minimum latency is one cycle per write; the boot takes 4*num_core_p handshakes.

Optional Feature:
Macro: BP_CFG_SEQ_BROADCAST_EN.
- Defined:
  - S_FREEZE is executed once before the per-core loop, as a broadcast with cfg_core_o = all-ones.
  - S_UNFREEZE is a single all-ones broadcast write.
  - Boot takes 2*num_core_p+2 handshakes.
- Undefined: per-core freeze and unfreeze, as described in Behaviour.

Decomposition:
- Package bp_cfg_seq_pkg holds:
  - state enum bp_cfg_seq_state_e
  - register address localparams (FREEZE, CORE_ID, CCE_MODE)
  - packed struct bp_cfg_bus_s (w, core, addr, data), parameterised through a width macro.
- One sub-module, bp_cfg_seq_mux: purely combinational select between boot-script fields and host fields, driven by the state.

Test Plan:
- num_core_p=2, cfg_ready_i=1, cce_mode_i=1 -> exactly 8 writes in order:
  - (c0,0x1,1), (c0,0x2,0), (c0,0x3,1)
  - (c1,0x1,1), (c1,0x2,1), (c1,0x3,1)
  - (c0,0x1,0), (c1,0x1,0)
  - boot_done_o rises the cycle after the 8th.
- Backpressure: cfg_ready_i toggles 0/1 randomly -> identical write sequence, and cfg_* fields are stable whenever cfg_v_o=1 and cfg_ready_i=0.
- Host write during boot (host_v_i=1 from cycle 0) -> host_ready_o=0 until boot_done_o; then write (c1,0x10,0xDEAD) appears on cfg_* in the same cycle.
- Host read addr 0x20, response 0xCAFE 3 cycles later -> host_resp_v_o=1 with 0xCAFE the same cycle. A second host_v_i during the wait is not accepted until the cycle after the response.
- reset_n_i pulsed low during S_MODE of core 1 -> outputs 0 immediately; after release the script restarts with (c0,0x1,1).
- BP_CFG_SEQ_BROADCAST_EN defined, num_core_p=2 -> 6 writes, with the first and last having cfg_core_o=8'hFF.

Source files
------------

// File: rtl/bp_cfg_seq_pkg.sv
// Shared types and register map for the config-bus boot sequencer.
// Bus field widths come from the BP_CFG_CORE_W / BP_CFG_ADDR_W / BP_CFG_DATA_W macros.
`ifndef BP_CFG_CORE_W
`define BP_CFG_CORE_W 8
`endif
`ifndef BP_CFG_ADDR_W
`define BP_CFG_ADDR_W 16
`endif
`ifndef BP_CFG_DATA_W
`define BP_CFG_DATA_W 64
`endif

package bp_cfg_seq_pkg;

    typedef enum logic [2:0] {
        S_FREEZE   = 3'd0,
        S_ID       = 3'd1,
        S_MODE     = 3'd2,
        S_UNFREEZE = 3'd3,
        S_IDLE     = 3'd4,
        S_RESP     = 3'd5
    } bp_cfg_seq_state_e;

    localparam logic [`BP_CFG_ADDR_W-1:0] FREEZE   = 16'h0001;
    localparam logic [`BP_CFG_ADDR_W-1:0] CORE_ID  = 16'h0002;
    localparam logic [`BP_CFG_ADDR_W-1:0] CCE_MODE = 16'h0003;

    typedef struct packed {
        logic                      w;
        logic [`BP_CFG_CORE_W-1:0] core;
        logic [`BP_CFG_ADDR_W-1:0] addr;
        logic [`BP_CFG_DATA_W-1:0] data;
    } bp_cfg_bus_s;

    function automatic bp_cfg_bus_s bp_cfg_write(
        input logic [`BP_CFG_CORE_W-1:0] core,
        input logic [`BP_CFG_ADDR_W-1:0] addr,
        input logic [`BP_CFG_DATA_W-1:0] data
    );
        bp_cfg_bus_s bus;
        bus.w    = 1'b1;
        bus.core = core;
        bus.addr = addr;
        bus.data = data;
        return bus;
    endfunction

endpackage

// File: rtl/bp_cfg_seq_mux.sv
// Selects who owns the config bus: the boot script, the host, or nobody
// while a host read waits for its response.
module bp_cfg_seq_mux
    import bp_cfg_seq_pkg::*;
(
    input  bp_cfg_seq_state_e state,
    input  bp_cfg_bus_s       boot_bus,
    input  logic              host_v,
    input  bp_cfg_bus_s       host_bus,
    output logic              cfg_v,
    output bp_cfg_bus_s       cfg_bus
);

    // Bus ownership by state.
    always_comb begin
        cfg_v   = 1'b0;
        cfg_bus = '0;
        case (state)
            S_FREEZE, S_ID, S_MODE, S_UNFREEZE: begin
                cfg_v   = 1'b1;
                cfg_bus = boot_bus;
            end
            S_IDLE: begin
                cfg_v   = host_v;
                cfg_bus = host_bus;
            end
            S_RESP: begin
                cfg_v   = 1'b0;
                cfg_bus = '0;
            end
            default: begin
                cfg_v   = 1'b0;
                cfg_bus = '0;
            end
        endcase
    end

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Boots every core over the config bus, then shares the bus with a host requester.
// Optional BP_CFG_SEQ_BROADCAST_EN: freeze/unfreeze become single all-ones broadcasts.
module bp_cfg_boot_sequencer
    import bp_cfg_seq_pkg::*;
#(
    parameter int num_core_p       = 1,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        cce_mode_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic                        cfg_w_o,
    output logic [cfg_core_width_p-1:0] cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_resp_v_i,
    input  logic [cfg_data_width_p-1:0] cfg_resp_data_i,
    input  logic                        host_v_i,
    output logic                        host_ready_o,
    input  logic                        host_w_i,
    input  logic [cfg_core_width_p-1:0] host_core_i,
    input  logic [cfg_addr_width_p-1:0] host_addr_i,
    input  logic [cfg_data_width_p-1:0] host_data_i,
    output logic                        host_resp_v_o,
    output logic [cfg_data_width_p-1:0] host_resp_data_o,
    output logic                        boot_done_o
);

    localparam int cnt_width_lp = $clog2(num_core_p) + 1;
    localparam int core_w_lp    = `BP_CFG_CORE_W;
    localparam int data_w_lp    = `BP_CFG_DATA_W;
    localparam logic [cnt_width_lp-1:0] last_core_lp = cnt_width_lp'(num_core_p - 1);

    bp_cfg_seq_state_e         state_r;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic                      run_r;
    logic                      done_r;
    logic                      mode_r;
    logic                      mode_held_r;
    logic                      mode_s;
    logic                      last_s;
    logic                      unfreeze_last_s;
    logic                      fire_s;
    logic [core_w_lp-1:0]      sweep_core_s;
    bp_cfg_seq_state_e         loop_state_s;
    bp_cfg_bus_s               boot_bus_s;
    bp_cfg_bus_s               host_bus_s;
    bp_cfg_bus_s               mux_bus_s;
    logic                      mux_v_s;

    assign last_s = (cnt_r == last_core_lp);

`ifdef BP_CFG_SEQ_BROADCAST_EN
    assign sweep_core_s    = '1;
    assign unfreeze_last_s = 1'b1;
    assign loop_state_s    = S_ID;
`else
    assign sweep_core_s    = core_w_lp'(cnt_r);
    assign unfreeze_last_s = last_s;
    assign loop_state_s    = S_FREEZE;
`endif

    assign host_bus_s.w    = host_w_i;
    assign host_bus_s.core = host_core_i;
    assign host_bus_s.addr = host_addr_i;
    assign host_bus_s.data = host_data_i;

    // Boot-script write for the current state; the mode bit is frozen once offered.
    always_comb begin
        mode_s = mode_held_r ? mode_r : cce_mode_i;
        case (state_r)
            S_FREEZE:   boot_bus_s = bp_cfg_write(sweep_core_s, FREEZE, data_w_lp'(1'b1));
            S_ID:       boot_bus_s = bp_cfg_write(core_w_lp'(cnt_r), CORE_ID, data_w_lp'(cnt_r));
            S_MODE:     boot_bus_s = bp_cfg_write(core_w_lp'(cnt_r), CCE_MODE, data_w_lp'(mode_s));
            S_UNFREEZE: boot_bus_s = bp_cfg_write(sweep_core_s, FREEZE, data_w_lp'(1'b0));
            default:    boot_bus_s = '0;
        endcase
    end

    bp_cfg_seq_mux u_mux (
        .state    (state_r),
        .boot_bus (boot_bus_s),
        .host_v   (host_v_i),
        .host_bus (host_bus_s),
        .cfg_v    (mux_v_s),
        .cfg_bus  (mux_bus_s)
    );

    // run_r keeps every bus output at zero while reset is asserted.
    assign cfg_v_o    = run_r & mux_v_s;
    assign cfg_w_o    = run_r & mux_bus_s.w;
    assign cfg_core_o = run_r ? mux_bus_s.core : '0;
    assign cfg_addr_o = run_r ? mux_bus_s.addr : '0;
    assign cfg_data_o = run_r ? mux_bus_s.data : '0;
    assign fire_s     = cfg_v_o & cfg_ready_i;

    assign host_ready_o     = (state_r == S_IDLE) & cfg_ready_i;
    assign host_resp_v_o    = (state_r == S_RESP) & cfg_resp_v_i;
    assign host_resp_data_o = host_resp_v_o ? cfg_resp_data_i : '0;
    assign boot_done_o      = done_r;

    // Boot script sequencing and single-outstanding host read tracking.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= S_FREEZE;
            cnt_r   <= '0;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            run_r <= 1'b1;
            case (state_r)
                S_FREEZE: if (fire_s) state_r <= S_ID;
                S_ID:     if (fire_s) state_r <= S_MODE;
                S_MODE: if (fire_s) begin
                    if (last_s) begin
                        cnt_r   <= '0;
                        state_r <= S_UNFREEZE;
                    end else begin
                        cnt_r   <= cnt_r + cnt_width_lp'(1);
                        state_r <= loop_state_s;
                    end
                end
                S_UNFREEZE: if (fire_s) begin
                    if (unfreeze_last_s) begin
                        state_r <= S_IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + cnt_width_lp'(1);
                    end
                end
                S_IDLE: if (fire_s && !host_w_i) state_r <= S_RESP;
                S_RESP: if (cfg_resp_v_i) state_r <= S_IDLE;
                default: state_r <= S_FREEZE;
            endcase
        end
    end

    // Captures cce_mode_i on the first cycle a MODE write stalls so the bus stays stable.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mode_r      <= 1'b0;
            mode_held_r <= 1'b0;
        end else if (fire_s) begin
            mode_held_r <= 1'b0;
        end else if (state_r == S_MODE && cfg_v_o && !mode_held_r) begin
            mode_r      <= cce_mode_i;
            mode_held_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Randomized bench for bp_cfg_boot_sequencer against a script/transaction model.
module tb_bp_cfg_boot_sequencer;

    localparam int NC = 2;
`ifdef BP_CFG_SEQ_BROADCAST_EN
    localparam int EXP_LEN   = 2 * NC + 2;
    localparam int MODE_C1_N = 4;
`else
    localparam int EXP_LEN   = 4 * NC;
    localparam int MODE_C1_N = 5;
`endif

    typedef struct packed {
        logic        w;
        logic [7:0]  core;
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        cce_mode_i = 1'b0;
    logic        cfg_v_o, cfg_w_o, cfg_ready_i = 1'b1;
    logic [7:0]  cfg_core_o;
    logic [15:0] cfg_addr_o;
    logic [63:0] cfg_data_o;
    logic        cfg_resp_v_i = 1'b0;
    logic [63:0] cfg_resp_data_i = 64'd0;
    logic        host_v_i = 1'b0, host_ready_o, host_w_i = 1'b0;
    logic [7:0]  host_core_i = 8'd0;
    logic [15:0] host_addr_i = 16'd0;
    logic [63:0] host_data_i = 64'd0;
    logic        host_resp_v_o, boot_done_o;
    logic [63:0] host_resp_data_o;

    bp_cfg_boot_sequencer #(.num_core_p(NC)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .cce_mode_i(cce_mode_i),
        .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_w_o(cfg_w_o),
        .cfg_core_o(cfg_core_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
        .cfg_resp_v_i(cfg_resp_v_i), .cfg_resp_data_i(cfg_resp_data_i),
        .host_v_i(host_v_i), .host_ready_o(host_ready_o), .host_w_i(host_w_i),
        .host_core_i(host_core_i), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
        .host_resp_v_o(host_resp_v_o), .host_resp_data_o(host_resp_data_o),
        .boot_done_o(boot_done_o)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  hs_cnt;
    bit  rand_rdy, rand_resp, model_done, done_pend, in_resp, prev_stall, host_hs;
    wr_t prev_bus;
    bit          nx_v, nx_w, nx_resp_v;
    logic [7:0]  nx_core;
    logic [15:0] nx_addr;
    logic [63:0] nx_data, nx_resp_data;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic wr_t mk(input logic w, input logic [7:0] c, input logic [15:0] a, input logic [63:0] d);
        wr_t t;
        t.w = w; t.core = c; t.addr = a; t.data = d;
        return t;
    endfunction

    // Expected boot writes built straight from the script rules.
    function automatic void build_script(input bit mode);
        exp_q.delete();
`ifdef BP_CFG_SEQ_BROADCAST_EN
        exp_q.push_back(mk(1'b1, 8'hFF, 16'h0001, 64'd1));
        for (int c = 0; c < NC; c++) begin
            exp_q.push_back(mk(1'b1, 8'(c), 16'h0002, 64'(c)));
            exp_q.push_back(mk(1'b1, 8'(c), 16'h0003, 64'(mode)));
        end
        exp_q.push_back(mk(1'b1, 8'hFF, 16'h0001, 64'd0));
`else
        for (int c = 0; c < NC; c++) begin
            exp_q.push_back(mk(1'b1, 8'(c), 16'h0001, 64'd1));
            exp_q.push_back(mk(1'b1, 8'(c), 16'h0002, 64'(c)));
            exp_q.push_back(mk(1'b1, 8'(c), 16'h0003, 64'(mode)));
        end
        for (int c = 0; c < NC; c++) exp_q.push_back(mk(1'b1, 8'(c), 16'h0001, 64'd0));
`endif
    endfunction

    task automatic apply_inputs();
        host_v_i = nx_v; host_w_i = nx_w; host_core_i = nx_core;
        host_addr_i = nx_addr; host_data_i = nx_data;
        cfg_resp_v_i = rand_resp ? 1'($urandom_range(0, 1)) : nx_resp_v;
        cfg_resp_data_i = rand_resp ? {$urandom, $urandom} : nx_resp_data;
        cfg_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One cycle: drive at negedge, sample 1ns later, compare with the model.
    task automatic step();
        wr_t bus, e;
        @(negedge clk);
        apply_inputs();
        #1;
        host_hs = 1'b0;
        if (done_pend) begin model_done = 1'b1; done_pend = 1'b0; end
        bus = mk(cfg_w_o, cfg_core_o, cfg_addr_o, cfg_data_o);
        chk("boot_done", 128'(boot_done_o), 128'(model_done));
        if (prev_stall) begin
            chk("hold_v", 128'(cfg_v_o), 128'(1'b1));
            chk("hold_bus", 128'(bus), 128'(prev_bus));
        end
        prev_stall = cfg_v_o && !cfg_ready_i;
        prev_bus = bus;
        chk("host_ready", 128'(host_ready_o), 128'(model_done && !in_resp && cfg_ready_i));
        chk("host_resp_v", 128'(host_resp_v_o), 128'(in_resp && cfg_resp_v_i));
        if (in_resp && cfg_resp_v_i) chk("host_resp_data", 128'(host_resp_data_o), 128'(cfg_resp_data_i));
        if (!model_done) begin
            if (cfg_v_o && cfg_ready_i) begin
                if (exp_q.size() == 0) chk("extra_write", 128'(1'b1), 128'(1'b0));
                else begin
                    e = exp_q.pop_front();
                    chk("boot_write", 128'(bus), 128'(e));
                    hs_cnt++;
                    if (exp_q.size() == 0) done_pend = 1'b1;
                end
            end
        end else if (in_resp) begin
            chk("resp_quiet_v", 128'(cfg_v_o), 128'(1'b0));
        end else begin
            chk("mirror_v", 128'(cfg_v_o), 128'(host_v_i));
            if (host_v_i) chk("mirror_bus", 128'(bus), 128'(mk(host_w_i, host_core_i, host_addr_i, host_data_i)));
        end
        if (in_resp) begin
            if (cfg_resp_v_i) in_resp = 1'b0;
        end else if (model_done && host_v_i && cfg_ready_i) begin
            host_hs = 1'b1;
            if (!host_w_i) in_resp = 1'b1;
        end
    endtask

    // Caller is positioned at a negedge; reset takes effect immediately.
    task automatic do_reset(input bit mode);
        reset_n_i = 1'b0;
        apply_inputs();
        #1;
        chk("rst_cfg_v", 128'(cfg_v_o), 128'(1'b0));
        chk("rst_cfg_bus", 128'(mk(cfg_w_o, cfg_core_o, cfg_addr_o, cfg_data_o)), 128'(0));
        chk("rst_host_ready", 128'(host_ready_o), 128'(1'b0));
        chk("rst_resp_v", 128'({host_resp_v_o, host_resp_data_o}), 128'(0));
        chk("rst_boot_done", 128'(boot_done_o), 128'(1'b0));
        repeat (2) @(negedge clk);
        cce_mode_i = mode;
        build_script(mode);
        model_done = 1'b0; done_pend = 1'b0; in_resp = 1'b0; prev_stall = 1'b0; hs_cnt = 0;
        reset_n_i = 1'b1;
    endtask

    task automatic run_boot();
        int n = 0;
        while (!model_done && n < 400) begin step(); n++; end
        chk("boot_timeout", 128'(model_done), 128'(1'b1));
        chk("boot_len", 128'(hs_cnt), 128'(EXP_LEN));
    endtask

    task automatic wait_host_hs(input string tag);
        int n = 0;
        step();
        while (!host_hs && n < 60) begin step(); n++; end
        chk(tag, 128'(host_hs), 128'(1'b1));
    endtask

    initial begin
        nx_v = 1'b0; nx_w = 1'b0; nx_core = 8'd0; nx_addr = 16'd0; nx_data = 64'd0;
        nx_resp_v = 1'b0; nx_resp_data = 64'd0; rand_rdy = 1'b0; rand_resp = 1'b0;

        // Plain boot, full-speed bus, mode 1, then a random mode.
        @(negedge clk); do_reset(1'b1); run_boot();
        @(negedge clk); do_reset(1'($urandom_range(0, 1))); run_boot();

        // Host write pending from reset, random backpressure and stray responses.
        nx_v = 1'b1; nx_w = 1'b1; nx_core = 8'd1; nx_addr = 16'h0010; nx_data = 64'hDEAD;
        rand_rdy = 1'b1; rand_resp = 1'b1;
        @(negedge clk); do_reset(1'($urandom_range(0, 1))); run_boot();
        wait_host_hs("host_write_hs");
        rand_resp = 1'b0; nx_v = 1'b0;

        // Host read with response three cycles later; second request waits.
        rand_rdy = 1'b0;
        nx_v = 1'b1; nx_w = 1'b0; nx_core = 8'($urandom); nx_addr = 16'h0020;
        wait_host_hs("host_read_hs");
        nx_w = 1'b1; nx_addr = 16'h0030; nx_data = {$urandom, $urandom};
        step(); chk("second_held_1", 128'(host_hs), 128'(1'b0));
        step(); chk("second_held_2", 128'(host_hs), 128'(1'b0));
        nx_resp_v = 1'b1; nx_resp_data = 64'hCAFE;
        step(); chk("read_resp", 128'({host_resp_v_o, host_resp_data_o}), 128'({1'b1, 64'hCAFE}));
        nx_resp_v = 1'b0;
        step(); chk("second_accept", 128'(host_hs), 128'(1'b1));
        nx_v = 1'b0;

        // Random host traffic with random responses and stray response pulses.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            nx_resp_v = in_resp ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            nx_resp_data = {$urandom, $urandom};
            if (!nx_v && $urandom_range(0, 1) == 1) begin
                nx_v = 1'b1; nx_w = 1'($urandom_range(0, 1)); nx_core = 8'($urandom);
                nx_addr = 16'($urandom); nx_data = {$urandom, $urandom};
            end
            step();
            if (host_hs) nx_v = 1'b0;
        end
        nx_v = 1'b0; nx_resp_v = 1'b0;

        // Reset while the MODE write of core 1 is offered; script restarts at core 0.
        rand_rdy = 1'b0;
        @(negedge clk); do_reset(1'b1);
        begin
            int n = 0;
            while (hs_cnt < MODE_C1_N && n < 100) begin step(); n++; end
        end
        chk("mid_hs_count", 128'(hs_cnt), 128'(MODE_C1_N));
        @(negedge clk); #1;
        chk("mid_mode_bus", 128'({cfg_v_o, cfg_core_o, cfg_addr_o}), 128'({1'b1, 8'd1, 16'h0003}));
        do_reset(1'b1);
        chk("restart_first", 128'(exp_q[0]), 128'(mk(1'b1, (EXP_LEN == 4 * NC) ? 8'd0 : 8'hFF, 16'h0001, 64'd1)));
        run_boot();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
